// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect input and decode-side output.
// master = fetch unit, slave = memory/decode environment.
interface instr_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] Instr;
    logic [31:0] pc;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output imem_req_valid, imem_req_addr, Instr, pc, instr_valid,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, Instr, pc, instr_valid,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: in-order imem requests, PC-tagged response queue, redirect with wrong-path drop.
// Latency: response word visible at decode the cycle after it returns; no request issued in BOOT.
// Backpressure: requests stall while outstanding+queued reaches QDEPTH. Optional IF_MISALIGN_CHK_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic Clk,
    input  logic Rst,
    instr_fetch_if.master bus
`ifdef IF_MISALIGN_CHK_EN
    ,
    output logic misalign_err
`endif
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] QD_W = QDEPTH[CW:0];

    typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [31:0]     qpc_q  [QDEPTH];
    logic [31:0]     qpc_d  [QDEPTH];
    logic [31:0]     qdat_q [QDEPTH];
    logic [31:0]     qdat_d [QDEPTH];
    logic            misalign_q, misalign_d;

    logic            redir_eff;
    logic [31:0]     redir_tgt;
    logic [CW:0]     credit_used;
    logic            req_vld;
    logic            acc;
    logic            rsp;
    logic            drop;
    logic            push;
    logic            pop;
    logic            empty;
    logic            out_vld;
    logic [31:0]     rsp_pc;
    logic [CW-1:0]   outstanding_dec;

    always_comb begin
        state_d         = state_q;
        fetch_pc_d      = fetch_pc_q;
        outstanding_d   = outstanding_q;
        drop_cnt_d      = drop_cnt_q;
        count_d         = count_q;
        head_d          = head_q;
        tail_d          = tail_q;
        qpc_d           = qpc_q;
        qdat_d          = qdat_q;
        misalign_d      = misalign_q;

        redir_eff   = bus.redirect && (state_q != BOOT);
        redir_tgt   = {bus.redirect_pc[31:2], 2'b00};
        credit_used = {1'b0, outstanding_q} + {1'b0, count_q};
        req_vld     = (state_q == RUN) && !bus.redirect && (credit_used < QD_W);
        acc         = req_vld && bus.imem_req_ready;
        rsp         = bus.imem_rsp_valid;
        drop        = rsp && (drop_cnt_q != '0);
        push        = rsp && !drop;
        empty       = (count_q == '0);
        out_vld     = !empty && !bus.redirect;
        pop         = out_vld && bus.instr_ready;
        // Live requests are the youngest ones, so the oldest one's PC sits that many words behind fetch_pc.
        rsp_pc      = fetch_pc_q - (32'(outstanding_q) << 2);

        outstanding_dec = (rsp && (outstanding_q != '0)) ? outstanding_q - CW'(1) : outstanding_q;
        outstanding_d   = acc ? outstanding_dec + CW'(1) : outstanding_dec;

        drop_cnt_d = drop ? drop_cnt_q - CW'(1) : drop_cnt_q;
        if (redir_eff && (state_q == RUN)) begin
            drop_cnt_d = outstanding_dec;
        end

        if (redir_eff) begin
            fetch_pc_d = redir_tgt;
        end else if (acc) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (redir_eff) begin
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            if (push) begin
                qpc_d[tail_q]  = rsp_pc;
                qdat_d[tail_q] = bus.imem_rsp_data;
                tail_d         = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

`ifdef IF_MISALIGN_CHK_EN
        if (redir_eff && (bus.redirect_pc[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
        end
`endif

        unique case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (redir_eff && (outstanding_d != '0)) state_d = DRAIN;
            DRAIN:   if (drop_cnt_d == '0) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q       <= BOOT;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            qpc_q         <= '{default: '0};
            qdat_q        <= '{default: '0};
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            qpc_q         <= qpc_d;
            qdat_q        <= qdat_d;
            misalign_q    <= misalign_d;
        end
    end

    assign bus.imem_req_valid = req_vld;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.instr_valid    = out_vld;
    assign bus.Instr          = empty ? 32'h0 : qdat_q[head_q];
    assign bus.pc             = empty ? 32'h0 : qpc_q[head_q];

`ifdef IF_MISALIGN_CHK_EN
    assign misalign_err = misalign_q;
`else
    logic unused_misalign;
    assign unused_misalign = misalign_q ^ (^bus.redirect_pc[1:0]);
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: variable-latency memory model plus an in-order PC-stream reference.
module tb_instr_fetch;
    localparam int QD = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_if bus();
`ifdef IF_MISALIGN_CHK_EN
    logic misalign_err;
`endif

    instr_fetch #(.RESET_PC(32'h0), .QDEPTH(QD)) dut (
        .Clk(clk),
        .Rst(rst),
        .bus(bus)
`ifdef IF_MISALIGN_CHK_EN
        ,
        .misalign_err(misalign_err)
`endif
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [31:0] mem_q[$];
    int          due_q[$];
    logic [31:0] pop_log[$];
    logic        redir = 1'b0;
    logic [31:0] redir_pc = 32'h0;
    logic        ir = 1'b0;
    logic        mr = 1'b0;
    int          lat = 1;
    bit          rand_lat = 1'b0;
    logic [31:0] exp_req_pc = 32'h0;
    logic [31:0] exp_out_pc = 32'h0;
    logic [31:0] last_req = 32'h0;
    int          npop = 0;
    int          nacc = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check/advance the reference model, commit memory at posedge.
    task automatic step();
        logic        rsp;
        logic        acc;
        logic        pop;
        logic [31:0] a;
        @(negedge clk);
        rsp = (mem_q.size() > 0) && (due_q[0] <= cyc);
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? memf(mem_q[0]) : 32'h0;
        bus.imem_req_ready = mr;
        bus.instr_ready    = ir;
        bus.redirect       = redir;
        bus.redirect_pc    = redir_pc;
        #1;
        acc = bus.imem_req_valid & mr;
        pop = bus.instr_valid & ir;
        a   = bus.imem_req_addr;
        if (redir) begin
            check("redir_instr_valid", 32'(bus.instr_valid), 32'd0);
            check("redir_req_valid", 32'(bus.imem_req_valid), 32'd0);
        end
        if (acc) begin
            check("req_addr", a, exp_req_pc);
            check("credit", (mem_q.size() < QD) ? 32'd1 : 32'd0, 32'd1);
            last_req = a;
            nacc++;
        end
        if (pop) begin
            check("out_pc", bus.pc, exp_out_pc);
            check("out_instr", bus.Instr, memf(exp_out_pc));
            pop_log.push_back(bus.pc);
            npop++;
            exp_out_pc += 32'd4;
        end
        if (redir) begin
            exp_req_pc = redir_pc & 32'hFFFF_FFFC;
            exp_out_pc = redir_pc & 32'hFFFF_FFFC;
        end else if (acc) begin
            exp_req_pc += 32'd4;
        end
        @(posedge clk);
        if (rsp) begin
            void'(mem_q.pop_front());
            void'(due_q.pop_front());
        end
        if (acc) begin
            mem_q.push_back(a);
            due_q.push_back(cyc + (rand_lat ? int'($urandom_range(1, 4)) : lat));
        end
        cyc++;
        redir = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        redir = 1'b0;
        bus.redirect       = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.imem_req_ready = 1'b0;
        bus.instr_ready    = 1'b0;
        mem_q.delete();
        due_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_instr", bus.Instr, 32'h0);
        check("rst_pc", bus.pc, 32'h0);
`ifdef IF_MISALIGN_CHK_EN
        check("rst_misalign", 32'(misalign_err), 32'd0);
`endif
        exp_req_pc = 32'h0;
        exp_out_pc = 32'h0;
    endtask

    task automatic wait_pops(input int n, input string tag);
        for (int i = 0; i < 60 && pop_log.size() < n; i++) step();
        if (pop_log.size() < n) check(tag, 32'(pop_log.size()), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n0;
        bit  found;
        rst = 1'b1;
        bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = 32'h0; bus.imem_req_ready = 1'b0; bus.instr_ready = 1'b0;

        // Streaming, fixed latency 1
        do_reset();
        mr = 1'b1; ir = 1'b1; lat = 1; rand_lat = 1'b0;
        pop_log.delete();
        n0 = npop;
        repeat (40) step();
        check("t1_progress", (npop - n0 >= 10) ? 32'd1 : 32'd0, 32'd1);
        if (pop_log.size() >= 3) begin
            check("t1_pc0", pop_log[0], 32'h0);
            check("t1_pc1", pop_log[1], 32'h4);
            check("t1_pc2", pop_log[2], 32'h8);
        end else begin
            check("t1_cnt", 32'(pop_log.size()), 32'd3);
        end

        // Decode stall: queue fills to exactly QDEPTH and fetch stops
        ir = 1'b0;
        repeat (10) step();
        #1;
        check("t2_ivld", 32'(bus.instr_valid), 32'd1);
        check("t2_req_stall", 32'(bus.imem_req_valid), 32'd0);
        check("t2_no_outstanding", 32'(mem_q.size()), 32'd0);
        check("t2_head_pc", bus.pc, exp_out_pc);
        ir = 1'b1;
        n0 = npop;
        step(); step();
        check("t2_two_pops", 32'(npop - n0), 32'd2);
        step();
        check("t2_only_two", 32'(npop - n0), 32'd2);

        // Redirect with two requests in flight, latency 3
        do_reset();
        lat = 3; mr = 1'b1; ir = 1'b1;
        for (int i = 0; i < 50 && mem_q.size() != 2; i++) step();
        check("t3_out2", 32'(mem_q.size()), 32'd2);
        redir = 1'b1; redir_pc = 32'h100;
        pop_log.delete();
        step();
        wait_pops(1, "t3_wait");
        if (pop_log.size() >= 1) check("t3_first_pc", pop_log[0], 32'h100);

        // Redirect in a cycle where a pop would otherwise happen
        lat = 1;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            step();
            #1;
            if (bus.instr_valid) found = 1'b1;
        end
        check("t4_found_valid", 32'(found), 32'd1);
        n0 = npop;
        redir = 1'b1; redir_pc = 32'h200;
        pop_log.delete();
        step();
        check("t4_no_pop", 32'(npop - n0), 32'd0);
        wait_pops(1, "t4_wait");
        if (pop_log.size() >= 1) check("t4_first_pc", pop_log[0], 32'h200);

        // Address wrap at the top of the space
        redir = 1'b1; redir_pc = 32'hFFFF_FFF8;
        pop_log.delete();
        step();
        wait_pops(3, "t5_wait");
        if (pop_log.size() >= 3) begin
            check("t5_pc0", pop_log[0], 32'hFFFF_FFF8);
            check("t5_pc1", pop_log[1], 32'hFFFF_FFFC);
            check("t5_pc2", pop_log[2], 32'h0000_0000);
        end

        // Misaligned redirect target: low bits dropped
        redir = 1'b1; redir_pc = 32'h102;
        n0 = nacc;
        step();
        for (int i = 0; i < 50 && nacc == n0; i++) step();
        check("t6_fetch_addr", last_req, 32'h100);
`ifdef IF_MISALIGN_CHK_EN
        check("t6_misalign_set", 32'(misalign_err), 32'd1);
        repeat (5) step();
        check("t6_misalign_sticky", 32'(misalign_err), 32'd1);
`endif

        // Randomized traffic, latency 1..4, random stalls and redirects
        rand_lat = 1'b1;
        n0 = npop;
        for (int i = 0; i < 800; i++) begin
            mr = ($urandom_range(0, 3) != 0);
            ir = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                redir = 1'b1;
                redir_pc = $urandom;
                if ($urandom_range(0, 3) != 0) redir_pc[1:0] = 2'b00;
            end
            step();
        end
        check("rand_progress", (npop - n0 >= 100) ? 32'd1 : 32'd0, 32'd1);

        // Mid-operation reset, then resume from RESET_PC
        do_reset();
        rand_lat = 1'b0; lat = 2; mr = 1'b1; ir = 1'b1;
        pop_log.delete();
        wait_pops(2, "rst_resume_wait");
        if (pop_log.size() >= 2) begin
            check("rst_resume_pc0", pop_log[0], 32'h0);
            check("rst_resume_pc1", pop_log[1], 32'h4);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
